// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and FSM encoding for the PS/2 scancode receiver
package ps2_pkg;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int         ENTRY_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction
endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-flop synchroniser followed by a FILTER_LEN-sample glitch filter
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);
    logic [1:0] sync;
    logic [7:0] cnt;

    // cnt counts consecutive samples that disagree with the current filtered level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == 8'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 frame receiver with E0/F0 prefix folding and a FWFT scancode FIFO
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2c,
    input  logic               ps2d,
    input  logic               rx_en,
    input  logic               rd_en,
    input  logic               clr_err,
    output logic [ENTRY_W-1:0] dout,
    output logic               valid,
    output logic               full,
    output logic               parity_err,
    output logic               frame_err,
    output logic               overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic c_filt, d_filt, c_q, fall;
    state_t state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [TW-1:0] to_cnt;
    logic par_bad, ext, brk, push, pe_ev, fe_ev;
    logic [ENTRY_W-1:0] push_data;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic empty, do_pop, do_push;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .reset(reset), .raw(ps2c), .filt(c_filt)
    );
    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk(clk), .reset(reset), .raw(ps2d), .filt(d_filt)
    );

    assign fall = c_q & ~c_filt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_q       <= 1'b1;
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            par_bad   <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            push      <= 1'b0;
            push_data <= '0;
            pe_ev     <= 1'b0;
            fe_ev     <= 1'b0;
        end else begin
            c_q   <= c_filt;
            push  <= 1'b0;
            pe_ev <= 1'b0;
            fe_ev <= 1'b0;
            if (!rx_en) begin
                state  <= IDLE;
                ext    <= 1'b0;
                brk    <= 1'b0;
                to_cnt <= '0;
            end else if (state == IDLE) begin
                to_cnt <= '0;
                if (fall && !d_filt) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
            end else if (!fall) begin
                if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    state  <= IDLE;
                    fe_ev  <= 1'b1;
                    ext    <= 1'b0;
                    brk    <= 1'b0;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
                if (state == DATA) begin
                    shreg   <= {d_filt, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= PARITY;
                end else if (state == PARITY) begin
                    par_bad <= ~odd_parity_ok(shreg, d_filt);
                    state   <= STOP;
                end else begin
                    state <= IDLE;
                    fe_ev <= ~d_filt;
                    pe_ev <= par_bad;
                    // prefixes are folded into flags; everything else is a scancode
                    if (d_filt && !par_bad && shreg == PS2_EXT) begin
                        ext <= 1'b1;
                    end else if (d_filt && !par_bad && shreg == PS2_BRK) begin
                        brk <= 1'b1;
                    end else begin
                        push      <= d_filt & ~par_bad;
                        push_data <= {ext, brk, shreg};
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                    end
                end
            end
        end
    end

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid   = ~empty;
    assign do_pop  = rd_en & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            parity_err <= pe_ev | (parity_err & ~clr_err);
            frame_err  <= fe_ev | (frame_err & ~clr_err);
            overflow   <= (push & full & ~do_pop) | (overflow & ~clr_err);
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed PS/2 frames with a queue scoreboard checked by a read monitor
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int FD   = 8;
    localparam int TO   = 1000;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ps2c = 1'b1, ps2d = 1'b1, rx_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [ENTRY_W-1:0] dout;
    logic valid, full, parity_err, frame_err, overflow;

    int errors = 0;
    int checks = 0;
    bit rd_on = 1'b0;
    logic [ENTRY_W-1:0] exp_q[$];

    ps2_scancode_rx #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .rd_en(rd_en), .clr_err(clr_err), .dout(dout), .valid(valid), .full(full),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops one expected entry whenever it issues a read of a valid head
    initial begin
        logic [ENTRY_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rd_on && valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL fifo_unexpected: got %0h expected none", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        errors++;
                        $display("FAIL fifo_head: got %0h expected %0h", dout, e);
                    end
                end
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2d = bits[i];
            cyc(HALF);
            ps2c = 1'b0;
            cyc(HALF);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        cyc(2 * HALF);
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
        send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        cyc(2);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 500 && (exp_q.size() != 0 || valid); i++) cyc(1);
        chk({name, "_q_empty"}, exp_q.size(), 0);
        chk({name, "_valid"}, valid, 0);
    endtask

    initial begin
        cyc(5);
        chk("rst_valid", valid, 0);
        chk("rst_full", full, 0);
        chk("rst_dout", dout, 0);
        chk("rst_flags", {parity_err, frame_err, overflow}, 0);
        reset = 1'b1;
        rx_en = 1'b1;
        rd_on = 1'b1;
        cyc(5);

        exp_q.push_back(10'h01C);
        exp_q.push_back(10'h11C);
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain("make_brk");
        chk("mb_perr", parity_err, 0);
        chk("mb_ferr", frame_err, 0);

        exp_q.push_back(10'h375);
        send(8'hE0); send(8'hF0); send(8'h75);
        drain("ext_brk");

        send(8'hF0);
        send(8'h2B, 1);
        chk("par_err_set", parity_err, 1);
        chk("par_valid", valid, 0);
        pulse_clr();
        chk("par_err_clr", parity_err, 0);
        exp_q.push_back(10'h02B);
        send(8'h2B);
        drain("after_par");

        send(8'h33, 0, 1);
        chk("stop_ferr", frame_err, 1);
        chk("stop_valid", valid, 0);
        pulse_clr();

        send_bits({2'b11, 8'h1C, 1'b0}, 5);
        cyc(TO + 10);
        chk("to_ferr", frame_err, 1);
        chk("to_state", dut.state, IDLE);
        pulse_clr();
        exp_q.push_back(10'h01C);
        send(8'h1C);
        drain("after_to");

        send(8'hE0);
        send_bits({2'b11, 8'h55, 1'b0}, 4);
        rx_en = 1'b0;
        cyc(5);
        chk("rxen_state", dut.state, IDLE);
        rx_en = 1'b1;
        exp_q.push_back(10'h01C);
        send(8'h1C);
        drain("after_rxen");

        rd_on = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(10'(8'h11 + i));
            send(8'(8'h11 + i));
        end
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", valid, 1);
        rd_on = 1'b1;
        drain("ovf");
        chk("ovf_full_after", full, 0);
        pulse_clr();
        chk("ovf_clr", overflow, 0);

        ps2d = 1'b0;
        ps2c = 1'b0;
        cyc(3);
        ps2c = 1'b1;
        cyc(2 * FL + 10);
        ps2d = 1'b1;
        chk("glitch_state", dut.state, IDLE);
        exp_q.push_back(10'h01C);
        send(8'h1C);
        drain("after_glitch");

        rd_on = 1'b0;
        send(8'h22);
        send(8'h2B, 1);
        send_bits({2'b11, 8'h1C, 1'b0}, 3);
        chk("pre_rst_valid", valid, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_flags", {parity_err, frame_err, overflow}, 0);
        chk("mid_rst_state", dut.state, IDLE);
        cyc(4);
        reset = 1'b1;
        rd_on = 1'b1;
        cyc(4);
        exp_q.push_back(10'h01C);
        send(8'h1C);
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
